// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA op enum, opcodes, field positions and encoder helpers shared with the processor decoder
package isa_pkg;

    typedef enum logic [3:0] {
        OP_R    = 4'd0,
        OP_J    = 4'd1,
        OP_BNE  = 4'd2,
        OP_JAL  = 4'd3,
        OP_JR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_BLT  = 4'd6,
        OP_SW   = 4'd7,
        OP_LW   = 4'd8,
        OP_SETX = 4'd9,
        OP_BEX  = 4'd10
    } op_t;

    localparam logic [4:0] OPC_R    = 5'b00000;
    localparam logic [4:0] OPC_J    = 5'b00001;
    localparam logic [4:0] OPC_BNE  = 5'b00010;
    localparam logic [4:0] OPC_JAL  = 5'b00011;
    localparam logic [4:0] OPC_JR   = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_BLT  = 5'b00110;
    localparam logic [4:0] OPC_SW   = 5'b00111;
    localparam logic [4:0] OPC_LW   = 5'b01000;
    localparam logic [4:0] OPC_SETX = 5'b10101;
    localparam logic [4:0] OPC_BEX  = 5'b10110;

    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_LSB   = 0;
    localparam int TGT_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [16:0] imm;
        logic [26:0] target;
    } enc_req_t;

    function automatic logic op_legal(logic [3:0] op);
        return op <= 4'd10;
    endfunction

    function automatic logic [4:0] opcode_of(logic [3:0] op);
        logic [4:0] opc;
        case (op)
            OP_R:    opc = OPC_R;
            OP_J:    opc = OPC_J;
            OP_BNE:  opc = OPC_BNE;
            OP_JAL:  opc = OPC_JAL;
            OP_JR:   opc = OPC_JR;
            OP_ADDI: opc = OPC_ADDI;
            OP_BLT:  opc = OPC_BLT;
            OP_SW:   opc = OPC_SW;
            OP_LW:   opc = OPC_LW;
            OP_SETX: opc = OPC_SETX;
            OP_BEX:  opc = OPC_BEX;
            default: opc = 5'b00000;
        endcase
        return opc;
    endfunction

    // Fields not belonging to the op's format are left zero in the word.
    function automatic logic [31:0] encode(enc_req_t r);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: 5] = opcode_of(r.op);
        case (r.op)
            OP_R: begin
                w[RD_LSB +: 5]    = r.rd;
                w[RS_LSB +: 5]    = r.rs;
                w[RT_LSB +: 5]    = r.rt;
                w[SHAMT_LSB +: 5] = r.shamt;
                w[ALUOP_LSB +: 5] = r.aluop;
            end
            OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: begin
                w[RD_LSB +: 5]   = r.rd;
                w[RS_LSB +: 5]   = r.rs;
                w[IMM_LSB +: 17] = r.imm;
            end
            OP_J, OP_JAL, OP_SETX, OP_BEX: begin
                w[TGT_LSB +: 27] = r.target;
            end
            OP_JR: begin
                w[RD_LSB +: 5] = r.rd;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - encoded-word FIFO; push ignored when full, pop ignored when empty
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction requests and streams the words into instruction memory
module instr_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_shamt,
    input  logic [4:0]        req_aluop,
    input  logic [16:0]       req_imm,
    input  logic [26:0]       req_target,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              imem_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              done,
    output logic              err_illegal,
    output logic              addr_wrap
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    enc_req_t          req;
    logic [31:0]       word;
    logic [31:0]       head;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
    logic              full;
    logic              empty;
    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic              next_empty;

    assign req = '{op: req_op, rd: req_rd, rs: req_rs, rt: req_rt, shamt: req_shamt,
                   aluop: req_aluop, imm: req_imm, target: req_target};
    assign word  = encode(req);
    assign legal = op_legal(req_op);

    assign req_ready = ~full && (state != ST_DRAIN);
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal;
    assign imem_we   = ~empty && ~imem_busy;
    assign pop       = imem_we;
    assign imem_data = head;
    assign imem_addr = addr;
    assign done      = (state == ST_DONE);

    // Occupancy after this edge, so DONE follows the last write directly.
    assign next_empty = ~push && (empty || (count == CNT_W'(1) && pop));

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            addr        <= '0;
            err_illegal <= 1'b0;
            addr_wrap   <= 1'b0;
        end else begin
            if (load_base) begin
                addr <= base_addr;
            end else if (imem_we) begin
                addr <= addr + ADDR_W'(1);
                if (&addr) begin
                    addr_wrap <= 1'b1;
                end
            end
            if (accept && !legal) begin
                err_illegal <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_next = ST_DRAIN;
                end else if (!next_empty) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (flush) begin
                    state_next = ST_DRAIN;
                end else if (next_empty) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (next_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed table-driven bench for instr_encoder
module tb_instr_encoder;
    import isa_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs, req_rt, req_shamt, req_aluop;
    logic [16:0] req_imm;
    logic [26:0] req_target;
    logic        load_base;
    logic [11:0] base_addr;
    logic        flush;
    logic        imem_busy;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        done;
    logic        err_illegal;
    logic        addr_wrap;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rs, rt, shamt, aluop;
        logic [16:0] imm;
        logic [26:0] target;
        logic [31:0] expect_word;
    } vec_t;

    vec_t vecs[12];

    instr_encoder dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_shamt   (req_shamt),
        .req_aluop   (req_aluop),
        .req_imm     (req_imm),
        .req_target  (req_target),
        .load_base   (load_base),
        .base_addr   (base_addr),
        .flush       (flush),
        .imem_busy   (imem_busy),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .done        (done),
        .err_illegal (err_illegal),
        .addr_wrap   (addr_wrap)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_req();
        req_op = 4'd0; req_rd = '0; req_rs = '0; req_rt = '0;
        req_shamt = '0; req_aluop = '0; req_imm = '0; req_target = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = 1'b0; load_base = 1'b0; base_addr = '0;
        flush = 1'b0; imem_busy = 1'b0;
        clear_req();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_j(input logic [26:0] t);
        clear_req();
        req_op = OP_J; req_target = t; req_valid = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v);
        req_op = v.op; req_rd = v.rd; req_rs = v.rs; req_rt = v.rt;
        req_shamt = v.shamt; req_aluop = v.aluop; req_imm = v.imm; req_target = v.target;
        req_valid = 1'b1;
    endtask

    initial begin
        int got, writes, dones, last_w, done_c, any_we;
        logic acc_now;

        //            op       rd     rs     rt     sh     alu    imm        target           expected
        vecs[0]  = '{OP_R,    5'd3,  5'd1,  5'd2,  5'd0,  5'd0,  17'h0,     27'h0,          32'h00C22000};
        vecs[1]  = '{OP_ADDI, 5'd5,  5'd0,  5'd0,  5'd0,  5'd0,  17'h1FFFF, 27'h0,          32'h2941FFFF};
        vecs[2]  = '{OP_JAL,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h0,     27'd100,        32'h18000064};
        vecs[3]  = '{OP_JR,   5'd31, 5'd7,  5'd3,  5'd1,  5'd1,  17'h5,     27'h55,         32'h27C00000};
        vecs[4]  = '{OP_SW,   5'd1,  5'd2,  5'd9,  5'd0,  5'd0,  17'h10,    27'h0,          32'h38440010};
        vecs[5]  = '{OP_R,    5'd1,  5'd2,  5'd3,  5'd4,  5'd3,  17'h1FFFF, 27'h7FFFFFF,    32'h0044320C};
        vecs[6]  = '{OP_BEX,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h0,     27'h7FFFFFF,    32'hB7FFFFFF};
        vecs[7]  = '{OP_SETX, 5'd9,  5'd0,  5'd0,  5'd0,  5'd0,  17'h3,     27'h5,          32'hA8000005};
        vecs[8]  = '{OP_LW,   5'd2,  5'd3,  5'd0,  5'd0,  5'd0,  17'h100,   27'h0,          32'h40860100};
        vecs[9]  = '{OP_BLT,  5'd1,  5'd2,  5'd0,  5'd0,  5'd0,  17'h1,     27'h0,          32'h30440001};
        vecs[10] = '{OP_BNE,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h1ABCD, 27'h0,          32'h1001ABCD};
        vecs[11] = '{OP_J,    5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h0,     27'h123,        32'h08000123};

        reset = 1'b1;
        do_reset();
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 12'h000);
        check("rst_done", done, 1'b0);
        check("rst_err", err_illegal, 1'b0);
        check("rst_wrap", addr_wrap, 1'b0);
        check("rst_ready", req_ready, 1'b1);

        // Encoding table: each word appears the cycle after accept at the next address.
        for (int i = 0; i < 12; i++) begin
            apply_vec(vecs[i]);
            @(negedge clock);
            req_valid = 1'b0;
            check($sformatf("vec%0d_we", i), imem_we, 1'b1);
            check($sformatf("vec%0d_addr", i), imem_addr, 32'(i));
            check($sformatf("vec%0d_data", i), imem_data, vecs[i].expect_word);
        end
        @(negedge clock);
        check("table_idle_we", imem_we, 1'b0);

        // Backpressure: 4 fill the FIFO, 5th waits, all 5 written in order after release.
        do_reset();
        imem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_j(27'(16 + i));
            if (i < 4) begin
                check($sformatf("busy_ready%0d", i), req_ready, 1'b1);
                @(negedge clock);
            end else begin
                check("busy_full_ready", req_ready, 1'b0);
            end
        end
        check("busy_hold_we", imem_we, 1'b0);
        imem_busy = 1'b0;
        #1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (imem_we) begin
                check($sformatf("rel_addr%0d", got), imem_addr, 32'(got));
                check($sformatf("rel_data%0d", got), imem_data, 32'h08000010 + 32'(got));
                got++;
            end
            acc_now = req_valid && req_ready;
            @(negedge clock);
            if (acc_now) req_valid = 1'b0;
        end
        check("rel_count", got, 5);

        // Address wrap from a loaded base, then load_base beating an increment.
        do_reset();
        load_base = 1'b1; base_addr = 12'hFFE;
        @(negedge clock);
        load_base = 1'b0;
        check("load_addr", imem_addr, 12'hFFE);
        drive_j(27'd1);
        @(negedge clock);
        check("wrap_we0", imem_we, 1'b1);
        check("wrap_addr0", imem_addr, 12'hFFE);
        drive_j(27'd2);
        @(negedge clock);
        check("wrap_addr1", imem_addr, 12'hFFF);
        check("wrap_flag_pre", addr_wrap, 1'b0);
        drive_j(27'd3);
        @(negedge clock);
        req_valid = 1'b0;
        check("wrap_addr2", imem_addr, 12'h000);
        check("wrap_data2", imem_data, 32'h08000003);
        check("wrap_flag", addr_wrap, 1'b1);
        @(negedge clock);
        check("wrap_idle_we", imem_we, 1'b0);
        check("wrap_sticky", addr_wrap, 1'b1);
        drive_j(27'd4);
        @(negedge clock);
        req_valid = 1'b0;
        check("prio_addr_pre", imem_addr, 12'h001);
        check("prio_we", imem_we, 1'b1);
        load_base = 1'b1; base_addr = 12'h100;
        @(negedge clock);
        load_base = 1'b0;
        check("prio_addr", imem_addr, 12'h100);
        check("prio_we_after", imem_we, 1'b0);

        // Illegal op: accepted, discarded, sticky error until reset.
        do_reset();
        clear_req();
        req_op = 4'd12; req_rd = 5'd7; req_valid = 1'b1;
        check("ill_ready", req_ready, 1'b1);
        @(negedge clock);
        req_valid = 1'b0;
        check("ill_we", imem_we, 1'b0);
        check("ill_err", err_illegal, 1'b1);
        repeat (3) @(negedge clock);
        check("ill_err_held", err_illegal, 1'b1);
        check("ill_we_held", imem_we, 1'b0);
        do_reset();
        check("ill_err_reset", err_illegal, 1'b0);

        // Flush with 3 queued words: 3 writes, one done right after the last.
        imem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_j(27'(32 + i));
            @(negedge clock);
        end
        req_valid = 1'b0;
        flush = 1'b1; imem_busy = 1'b0;
        #1;
        writes = 0; dones = 0; last_w = -1; done_c = -1;
        for (int c = 0; c < 12; c++) begin
            if (imem_we) begin writes++; last_w = c; end
            if (done) begin dones++; done_c = c; end
            if (c == 1) check("drain_ready", req_ready, 1'b0);
            @(negedge clock);
            flush = 1'b0;
        end
        check("drain_writes", writes, 3);
        check("drain_dones", dones, 1);
        check("drain_done_cycle", done_c, last_w + 1);
        check("drain_end_addr", imem_addr, 12'h003);

        // Reset in the middle of a drain abandons the remaining words.
        do_reset();
        imem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_j(27'(48 + i));
            @(negedge clock);
        end
        req_valid = 1'b0;
        flush = 1'b1; imem_busy = 1'b0;
        @(negedge clock);
        flush = 1'b0;
        check("mid_addr_pre", imem_addr, 12'h001);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_we", imem_we, 1'b0);
        check("mid_addr", imem_addr, 12'h000);
        check("mid_done", done, 1'b0);
        any_we = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (imem_we || done) any_we++;
        end
        check("mid_quiet", any_we, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning encoded-word FIFO depth (power of 2, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 12, meaning instruction-memory address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Port: clock  in  1  rising-edge clock.
REQ-004 SHALL have port: reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port: req_valid  in  1  encode request present.
REQ-006 SHALL have port: req_ready  out  1  request accepted this edge when high with req_valid.
REQ-007 SHALL have port: req_op  in  4  mnemonic: 0 R, 1 j, 2 bne, 3 jal, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw, 9 setx, 10 bex.
REQ-008 SHALL have ports: req_rd, req_rs, req_rt, req_shamt, req_aluop  in  5 each  register/shift/ALU fields.
REQ-009 SHALL have port: req_imm  in  17  I-type immediate.
REQ-010 SHALL have port: req_target  in  27  J-type target.
REQ-011 SHALL have ports: load_base  in  1 and base_addr  in  ADDR_W; load_base is a pulse that sets the write address.
REQ-012 SHALL have port: flush  in  1  pulse requesting a drain with completion notice.
REQ-013 SHALL have port: imem_busy  in  1  memory cannot take a write this cycle.
REQ-014 SHALL have ports: imem_we  out  1, imem_addr  out  ADDR_W, imem_data  out  32  instruction-memory write port.
REQ-015 SHALL have ports: done  out  1 (one-cycle drain-complete pulse), err_illegal  out  1 (sticky), addr_wrap  out  1 (sticky).

Function
REQ-016 SHALL encode R format as opcode 00000 [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2], with [1:0] = 0.
REQ-017 SHALL encode addi(00101), sw(00111), lw(01000), bne(00010) and blt(00110) in I format: opcode, rd [26:22], rs [21:17], imm [16:0].
REQ-018 SHALL encode j(00001), jal(00011), setx(10101) and bex(10110) in JI format: opcode, target [26:0].
REQ-019 SHALL encode jr(00100) in JII format: opcode, rd [26:22], with [21:0] = 0.
REQ-020 SHALL encode combinationally at the input and push the word into the FIFO on the accepting edge.
REQ-021 SHALL drive req_ready = ~full and state != DRAIN; when full, no push occurs even if a pop happens in the same cycle.
REQ-022 SHALL accept and discard illegal req_op values (11-15) with no FIFO push, and set err_illegal.
REQ-023 SHALL drive imem_we = ~empty and ~imem_busy; imem_data = FIFO head; imem_addr = write counter.
REQ-024 SHALL, on each edge where imem_we is high, pop the head and increment the counter modulo 2^ADDR_W.
REQ-025 SHALL set addr_wrap when the counter goes from all-ones to 0.
REQ-026 SHALL make a word accepted at edge N visible on imem_* from cycle N+1 (if imem_busy is low); throughput is 1 word per cycle.
REQ-027 SHALL, on load_base, load the counter from base_addr; load_base takes priority over an increment on the same edge.
REQ-028 SHALL implement FSM states IDLE (FIFO empty), ACTIVE (FIFO non-empty), DRAIN and DONE.
REQ-029 SHALL take the IDLE<->ACTIVE transitions on FIFO occupancy.
REQ-030 SHALL move from IDLE or ACTIVE to DRAIN on flush.
REQ-031 SHALL move from DRAIN to DONE when the FIFO is empty; from DONE it returns to IDLE after 1 cycle.
REQ-032 SHALL assert done only in DONE.
REQ-033 SHALL ignore flush while in DRAIN or DONE.
REQ-034 SHALL, on a simultaneous push and pop while not full, leave the FIFO count unchanged.

Reset
REQ-035 SHALL, on reset, clear the FIFO, set the counter to 0, set the state to IDLE, and set imem_we, done, err_illegal and addr_wrap to 0, all effective the cycle after.
REQ-036 SHALL, on reset mid-drain, abandon pending words without writing them.

Structure
REQ-037 SHALL place the op enum, 5-bit opcode constants and field bit positions in shared package isa_pkg, alongside the processor decoder.
REQ-038 SHALL implement the FIFO as sub-module instr_fifo (DEPTH, 32-bit width, push/pop/full/empty).

Verification
REQ-039 SHALL verify: op R, rd=3, rs=1, rt=2, shamt=0, aluop=0 -> imem_data 0x00C22000 at addr 0 one cycle after accept.
REQ-040 SHALL verify: addi rd=5, rs=0, imm=0x1FFFF -> 0x2941FFFF; jal target=100 -> 0x18000064.
REQ-041 SHALL verify: imem_busy high, 5 back-to-back requests with DEPTH=4 -> req_ready low after the 4th; on release, 5 writes occur at consecutive addresses.
REQ-042 SHALL verify: load_base with 0xFFE, then 3 requests -> addresses 0xFFE, 0xFFF, 0x000 and addr_wrap=1.
REQ-043 SHALL verify: req_op=12 -> no imem_we, err_illegal=1 held until reset.
REQ-044 SHALL verify: 3 queued words, flush, imem_busy low -> 3 writes, done pulses once in the next cycle; a reset asserted mid-drain -> imem_we 0 and addr 0 the following cycle.
